// File: rtl/steer_cond_sched.sv
// Conversion-round scheduler for the left/right load cells on the shared A2D,
// producing registered rider-condition flags and the settle timer.
module steer_cond_sched #(
  parameter logic [11:0] MIN_RIDER_WEIGHT = 12'h200,
  parameter logic [11:0] HYSTERESIS       = 12'h040,
  parameter logic [2:0]  CH_L             = 3'd0,
  parameter logic [2:0]  CH_R             = 3'd4,
  parameter logic [19:0] SMPL_PERIOD      = 20'd1_000_000,
  parameter logic [15:0] WAIT_TIMEOUT     = 16'd50_000,
  parameter logic [25:0] TMR_FULL         = 26'd65_000_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        cnv_req,
  output logic [2:0]  chnl,
  input  logic        cnv_done,
  input  logic [11:0] res,
  input  logic        clr_tmr,
  output logic [11:0] lft_ld,
  output logic [11:0] rght_ld,
  output logic        sum_gt_min,
  output logic        sum_lt_min,
  output logic        diff_gt_1_4,
  output logic        diff_gt_15_16,
  output logic        tmr_full,
  output logic        vld,
  output logic        a2d_err
);

  typedef enum logic [2:0] {IDLE, REQ_L, WAIT_L, REQ_R, WAIT_R, UPDATE} state_t;

  localparam logic [12:0] SUM_HI = {1'b0, MIN_RIDER_WEIGHT} + {1'b0, HYSTERESIS};
  localparam logic [12:0] SUM_LO = {1'b0, MIN_RIDER_WEIGHT} - {1'b0, HYSTERESIS};

  state_t      state_q, state_d;
  logic [19:0] per_cnt_q, per_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        cnv_req_q, cnv_req_d;
  logic [2:0]  chnl_q, chnl_d;
  logic [11:0] hold_l_q, hold_l_d;
  logic [11:0] hold_r_q, hold_r_d;
  logic [11:0] lft_q, lft_d;
  logic [11:0] rght_q, rght_d;
  logic        sum_gt_q, sum_gt_d;
  logic        sum_lt_q, sum_lt_d;
  logic        d14_q, d14_d;
  logic        d1516_q, d1516_d;
  logic        vld_q, vld_d;
  logic        err_q, err_d;
  logic [25:0] tmr_cnt_q, tmr_cnt_d;

  logic [12:0] sum;
  logic [11:0] diff;
  logic [16:0] sum_x15;
  logic        flag_d14;
  logic        flag_d1516;

  // Flag arithmetic works off the holding registers, so it is settled by UPDATE.
  always_comb begin
    sum        = {1'b0, hold_l_q} + {1'b0, hold_r_q};
    diff       = (hold_l_q >= hold_r_q) ? (hold_l_q - hold_r_q) : (hold_r_q - hold_l_q);
    sum_x15    = {sum, 4'b0000} - {4'b0000, sum};
    flag_d14   = {diff, 2'b00} > {1'b0, sum};
    flag_d1516 = {1'b0, diff, 4'b0000} > sum_x15;
  end

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    tmo_cnt_d = tmo_cnt_q;
    cnv_req_d = cnv_req_q;
    chnl_d    = chnl_q;
    hold_l_d  = hold_l_q;
    hold_r_d  = hold_r_q;
    lft_d     = lft_q;
    rght_d    = rght_q;
    sum_gt_d  = sum_gt_q;
    sum_lt_d  = sum_lt_q;
    d14_d     = d14_q;
    d1516_d   = d1516_q;
    vld_d     = 1'b0;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (per_cnt_q == SMPL_PERIOD - 20'd1) begin
          per_cnt_d = '0;
          state_d   = REQ_L;
        end else begin
          per_cnt_d = per_cnt_q + 20'd1;
        end
      end
      REQ_L: begin
        cnv_req_d = 1'b1;
        chnl_d    = CH_L;
        tmo_cnt_d = '0;
        state_d   = WAIT_L;
      end
      WAIT_L: begin
        if (cnv_done) begin
          hold_l_d  = res;
          cnv_req_d = 1'b0;
          state_d   = REQ_R;
        end else if (tmo_cnt_q == WAIT_TIMEOUT - 16'd1) begin
          cnv_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      REQ_R: begin
        cnv_req_d = 1'b1;
        chnl_d    = CH_R;
        tmo_cnt_d = '0;
        state_d   = WAIT_R;
      end
      WAIT_R: begin
        if (cnv_done) begin
          hold_r_d  = res;
          cnv_req_d = 1'b0;
          state_d   = UPDATE;
        end else if (tmo_cnt_q == WAIT_TIMEOUT - 16'd1) begin
          cnv_req_d = 1'b0;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      UPDATE: begin
        lft_d    = hold_l_q;
        rght_d   = hold_r_q;
        sum_gt_d = sum > SUM_HI;
        sum_lt_d = sum < SUM_LO;
        d14_d    = flag_d14;
        d1516_d  = flag_d1516;
        vld_d    = 1'b1;
        err_d    = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Settle timer: clear wins, otherwise count up and saturate at the terminal value.
  always_comb begin
    tmr_cnt_d = tmr_cnt_q;
    if (clr_tmr) begin
      tmr_cnt_d = '0;
    end else if (tmr_cnt_q < TMR_FULL) begin
      tmr_cnt_d = tmr_cnt_q + 26'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      per_cnt_q <= '0;
      tmo_cnt_q <= '0;
      cnv_req_q <= 1'b0;
      chnl_q    <= CH_L;
      hold_l_q  <= '0;
      hold_r_q  <= '0;
      lft_q     <= '0;
      rght_q    <= '0;
      sum_gt_q  <= 1'b0;
      sum_lt_q  <= 1'b1;
      d14_q     <= 1'b0;
      d1516_q   <= 1'b0;
      vld_q     <= 1'b0;
      err_q     <= 1'b0;
      tmr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      tmo_cnt_q <= tmo_cnt_d;
      cnv_req_q <= cnv_req_d;
      chnl_q    <= chnl_d;
      hold_l_q  <= hold_l_d;
      hold_r_q  <= hold_r_d;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
      sum_gt_q  <= sum_gt_d;
      sum_lt_q  <= sum_lt_d;
      d14_q     <= d14_d;
      d1516_q   <= d1516_d;
      vld_q     <= vld_d;
      err_q     <= err_d;
      tmr_cnt_q <= tmr_cnt_d;
    end
  end

  assign cnv_req       = cnv_req_q;
  assign chnl          = chnl_q;
  assign lft_ld        = lft_q;
  assign rght_ld       = rght_q;
  assign sum_gt_min    = sum_gt_q;
  assign sum_lt_min    = sum_lt_q;
  assign diff_gt_1_4   = d14_q;
  assign diff_gt_15_16 = d1516_q;
  assign tmr_full      = (tmr_cnt_q == TMR_FULL);
  assign vld           = vld_q;
  assign a2d_err       = err_q;

endmodule
